// File: rtl/regfile_pkg.sv
// Shared constants and types for the Rissy 16-bit CPU register file.
package regfile_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;
    localparam int PC_REG   = 7;

    typedef logic [DATA_W-1:0]   word_t;
    typedef logic [ADDR_W-1:0]   reg_idx_t;
    typedef word_t [NUM_REGS-1:0] reg_array_t;

    localparam reg_idx_t PC_IDX = reg_idx_t'(PC_REG);

endpackage

// File: rtl/register_file_8x16_if.sv
// Decode/execute-facing bus of the register file: one write port, two read ports, PC tap.
interface register_file_8x16_if;
    import regfile_pkg::*;

    logic     write_en;
    logic     read_en;
    word_t    write_data;
    reg_idx_t write_add;
    reg_idx_t ra_add;
    reg_idx_t rb_add;
    word_t    address;
    word_t    data_a;
    word_t    data_b;

    modport master (
        output write_en, read_en, write_data, write_add, ra_add, rb_add,
        input  address, data_a, data_b
    );

    modport slave (
        input  write_en, read_en, write_data, write_add, ra_add, rb_add,
        output address, data_a, data_b
    );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: 8:1 mux, optional write-data forwarding, read-enable gating.
// Forwarding is built only when REGFILE_BYPASS_EN is defined.
module regfile_read_port
    import regfile_pkg::*;
(
    input  logic       rst,
    input  reg_array_t regs_i,
    input  reg_idx_t   idx_i,
    input  logic       read_en_i,
    input  logic       write_en_i,
    input  reg_idx_t   write_add_i,
    input  word_t      write_data_i,
    output word_t      data_o
);

    word_t sel;

    always_comb begin
        // NOTE: default first so every path assigns sel and no latch is inferred.
        sel = regs_i[idx_i];
`ifdef REGFILE_BYPASS_EN
        if (write_en_i && rst && (idx_i == write_add_i)) begin
            sel = write_data_i;
        end
`endif
        data_o = read_en_i ? sel : '0;
    end

`ifndef REGFILE_BYPASS_EN
    // Write-side inputs only feed the forwarding compare.
    logic bypass_unused;
    assign bypass_unused = ^{rst, write_en_i, write_add_i, write_data_i};
`endif

endmodule

// File: rtl/register_file_8x16.sv
// 8 x 16-bit register file: array storage and write decode; reads via regfile_read_port.
// Optional write-to-read forwarding: define REGFILE_BYPASS_EN.
module register_file_8x16
    import regfile_pkg::*;
(
    input logic                 clk,
    input logic                 rst,
    register_file_8x16_if.slave rf
);

    reg_array_t regs_q;
    reg_array_t regs_d;

    // Index only under write_en so unknown indices never touch the array.
    always_comb begin
        regs_d = regs_q;
        if (rf.write_en) begin
            regs_d[rf.write_add] = rf.write_data;
        end
    end

    // NOTE: the whole array is reset; fetch relies on PC_REG starting at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_read_port u_port_a (
        .rst          (rst),
        .regs_i       (regs_q),
        .idx_i        (rf.ra_add),
        .read_en_i    (rf.read_en),
        .write_en_i   (rf.write_en),
        .write_add_i  (rf.write_add),
        .write_data_i (rf.write_data),
        .data_o       (rf.data_a)
    );

    regfile_read_port u_port_b (
        .rst          (rst),
        .regs_i       (regs_q),
        .idx_i        (rf.rb_add),
        .read_en_i    (rf.read_en),
        .write_en_i   (rf.write_en),
        .write_add_i  (rf.write_add),
        .write_data_i (rf.write_data),
        .data_o       (rf.data_b)
    );

    // Fetch address: fixed PC index, never gated by read_en.
    regfile_read_port u_port_pc (
        .rst          (rst),
        .regs_i       (regs_q),
        .idx_i        (PC_IDX),
        .read_en_i    (1'b1),
        .write_en_i   (rf.write_en),
        .write_add_i  (rf.write_add),
        .write_data_i (rf.write_data),
        .data_o       (rf.address)
    );

endmodule

// File: tb/tb_register_file_8x16.sv
// Directed self-checking bench for register_file_8x16 (both bypass builds).
module tb_register_file_8x16;
    import regfile_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    register_file_8x16_if rf ();

    register_file_8x16 dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input word_t obs, input word_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_reg(input reg_idx_t idx, input word_t data);
        @(negedge clk);
        rf.write_en   = 1'b1;
        rf.write_add  = idx;
        rf.write_data = data;
        @(posedge clk);
        #1;
        rf.write_en   = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b0;
        rf.write_en   = 1'b0;
        rf.read_en    = 1'b1;
        rf.write_data = '0;
        rf.write_add  = '0;
        rf.ra_add     = '0;
        rf.rb_add     = '0;

        // Power-on reset state.
        #1;
        check("por_address", rf.address, 16'h0000);
        check("por_data_a",  rf.data_a,  16'h0000);
        check("por_data_b",  rf.data_b,  16'h0000);

        // Writes are blocked while reset is held.
        write_reg(3'd7, 16'hDEAD);
        check("write_in_reset", rf.address, 16'h0000);

        @(negedge clk);
        rst = 1'b1;

        // 1. Preload, then asynchronous reset clears immediately.
        write_reg(3'd2, 16'hA5A5);
        write_reg(3'd7, 16'h1234);
        rf.ra_add = 3'd2;
        rf.rb_add = 3'd7;
        #1;
        check("preload_a",       rf.data_a,  16'hA5A5);
        check("preload_b",       rf.data_b,  16'h1234);
        check("preload_address", rf.address, 16'h1234);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_address", rf.address, 16'h0000);
        check("rst_data_a",  rf.data_a,  16'h0000);
        check("rst_data_b",  rf.data_b,  16'h0000);
        for (int k = 0; k < NUM_REGS; k++) begin
            rf.ra_add = reg_idx_t'(k);
            #1;
            check($sformatf("rst_reg%0d", k), rf.data_a, 16'h0000);
        end
        @(negedge clk);
        rst = 1'b1;

        // 2. Write 16'h1111*k into reg k and read back.
        for (int k = 0; k < NUM_REGS; k++) begin
            write_reg(reg_idx_t'(k), word_t'(16'h1111 * k));
        end
        rf.read_en = 1'b1;
        rf.ra_add  = 3'd2;
        rf.rb_add  = 3'd3;
        #1;
        check("rd_data_a",  rf.data_a,  16'h2222);
        check("rd_data_b",  rf.data_b,  16'h3333);
        check("rd_address", rf.address, 16'h7777);
        for (int k = 0; k < NUM_REGS; k++) begin
            rf.ra_add = reg_idx_t'(k);
            rf.rb_add = reg_idx_t'(NUM_REGS - 1 - k);
            #1;
            check($sformatf("sweep_a%0d", k), rf.data_a, word_t'(16'h1111 * k));
            check($sformatf("sweep_b%0d", k), rf.data_b, word_t'(16'h1111 * (NUM_REGS - 1 - k)));
        end
        rf.ra_add = 3'd5;
        rf.rb_add = 3'd5;
        #1;
        check("same_idx_a", rf.data_a, 16'h5555);
        check("same_idx_b", rf.data_b, 16'h5555);

        // 3. read_en=0 zeroes both ports but not address.
        rf.read_en = 1'b0;
        rf.ra_add  = 3'd6;
        rf.rb_add  = 3'd1;
        #1;
        check("ren0_data_a",  rf.data_a,  16'h0000);
        check("ren0_data_b",  rf.data_b,  16'h0000);
        check("ren0_address", rf.address, 16'h7777);
        rf.read_en = 1'b1;

        // 4. Unknown write bus with write_en=0 for 10 clocks.
        @(negedge clk);
        rf.write_en   = 1'b0;
        rf.write_data = 'x;
        rf.write_add  = 'x;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rf.write_data = '0;
        rf.write_add  = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            rf.ra_add = reg_idx_t'(k);
            #1;
            check($sformatf("hold_reg%0d", k), rf.data_a, word_t'(16'h1111 * k));
        end
        check("hold_address", rf.address, 16'h7777);

        // 5. Read/write collision on reg 4.
        @(negedge clk);
        rf.ra_add     = 3'd4;
        rf.rb_add     = 3'd3;
        rf.write_en   = 1'b1;
        rf.write_add  = 3'd4;
        rf.write_data = 16'hBEEF;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("coll_pre_a", rf.data_a, 16'hBEEF);
`else
        check("coll_pre_a", rf.data_a, 16'h4444);
`endif
        check("coll_pre_b", rf.data_b, 16'h3333);
        @(posedge clk);
        #1;
        rf.write_en = 1'b0;
        #1;
        check("coll_post_a", rf.data_a, 16'hBEEF);

        // PC register is writable; collision on the address tap.
        @(negedge clk);
        rf.write_en   = 1'b1;
        rf.write_add  = 3'd7;
        rf.write_data = 16'h7A7A;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("pc_coll_pre", rf.address, 16'h7A7A);
`else
        check("pc_coll_pre", rf.address, 16'h7777);
`endif
        @(posedge clk);
        #1;
        rf.write_en = 1'b0;
        #1;
        check("pc_coll_post", rf.address, 16'h7A7A);

        // 6. Reset falls on the same edge as a write to reg 5.
        @(negedge clk);
        rf.ra_add     = 3'd5;
        rf.write_en   = 1'b1;
        rf.write_add  = 3'd5;
        rf.write_data = 16'hC0DE;
        @(posedge clk);
        rst = 1'b0;
        #1;
        rf.write_en = 1'b0;
        check("rst_vs_wr_in_rst", rf.data_a, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_vs_wr_reg5",    rf.data_a,  16'h0000);
        check("rst_vs_wr_address", rf.address, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
